mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port synchronous unified memory among three requesters: data
//   access (MEM stage), instruction fetch (IF stage), and the debug readout feeding
//   the seven-segment display.
// - Sits between the pipeline and the memory macro inside top.
// - Grants at most one access per cycle and returns read data one cycle after grant.
// - Raises a fetch stall when fetch loses arbitration.
// PARAMETERS
// AW            10   memory word-address width
// DBG_PERIOD    64   cycles between automatic debug refresh reads
// DBG_MAX_WAIT  8    cycles a pending debug read waits before it is forced
// PORTS
// clk        in   1   rising-edge clock
// rst_n      in   1   asynchronous reset, active low
// if_req     in   1   fetch read request
// if_addr    in   32  fetch byte address
// if_gnt     out  1   fetch granted this cycle
// if_rvalid  out  1   if_rdata valid (cycle after if_gnt)
// if_rdata   out  32  fetch read data
// dm_req     in   1   data request
// dm_we      in   1   1 = write, 0 = read
// dm_addr    in   32  data byte address
// dm_wdata   in   32  data write value
// dm_gnt     out  1   data granted this cycle
// dm_rvalid  out  1   dm_rdata valid (reads only, cycle after dm_gnt)
// dm_rdata   out  32  data read value
// addr_sel   in   8   debug word address (zero-extended to AW)
// dbg_data   out  32  last debug read value, held
// dbg_fresh  out  1   one-cycle pulse when dbg_data updates
// stall_if   out  1   if_req & ~if_gnt
// mem_en     out  1   memory enable
// mem_we     out  1   memory write enable
// mem_addr   out  AW  memory word address
// mem_wdata  out  32  memory write data
// mem_rdata  in   32  memory read data, registered in memory (1-cycle latency)
// BEHAVIOUR
// - Reset: all outputs 0; dbg_data=0; owner tag=NONE; debug pending=1 (first read after
//   reset); age and period counters=0.
// - Word address = byte_addr[AW+1:2]; bits [1:0] ignored.
// - Grant is combinational in the request cycle. Priority: forced debug > data >
//   fetch > debug.
// - Debug pending sets on: period counter reaching DBG_PERIOD-1 (counter then wraps
//   to 0), or addr_sel differing from its registered copy. Pending clears on debug
//   grant.
// - Age counter: increments each cycle pending and not granted; saturates at
//   DBG_MAX_WAIT; clears on grant.
// - Forced debug: pending & age==DBG_MAX_WAIT. It preempts data and fetch for exactly
//   one cycle.
// - mem_* follow the granted source combinationally. mem_en=0 when no grant.
//   mem_we=dm_we only on dm grant.
// - Owner tag register {NONE, IF, DM_RD, DBG} latches the granted read source. Next
//   cycle:
//   - IF: if_rvalid=1
//   - DM_RD: dm_rvalid=1
//   - DBG: dbg_data<=mem_rdata, dbg_fresh=1
//   - a data write latches NONE.
// - if_rdata/dm_rdata = mem_rdata, unmasked; meaningful only with rvalid.
// - Simultaneous pending-set and grant in the same cycle: pending stays 1.
// - Reset mid-access drops the in-flight return: no rvalid after reset release.
// - Requesters hold req/addr until gnt. The arbiter has no queue.
// STRUCTURE
// - Shared package mem_arb_pkg holds the owner-tag encoding (NONE=0, IF=1, DM_RD=2,
//   DBG=3) and the byte-to-word address macro.
// - One sub-module, dbg_refresh_timer: period counter, addr_sel change detect, pending
//   flag and age counter. It outputs dbg_pending and dbg_force.
// TESTING
// - Reset, then idle 1 cycle -> debug read of word 0 granted, next cycle dbg_fresh=1
//   and dbg_data=mem[0].
// - if_req only, if_addr=0x10 -> if_gnt same cycle, mem_addr=4; next cycle
//   if_rvalid=1, if_rdata=mem[4].
// - if_req and dm_req read 0x20 together -> dm_gnt=1, if_gnt=0, stall_if=1; next
//   cycle fetch granted.
// - dm write 0x8 value 0xDEADBEEF -> mem_we=1, mem_addr=2, no dm_rvalid; later read
//   of 0x8 returns 0xDEADBEEF.
// - Continuous dm_req with addr_sel changed to 5 -> debug forced after 8 waiting
//   cycles, dm_gnt=0 for that one cycle, dbg_data=mem[5].
// - rst_n low in the cycle after an IF grant -> if_rvalid stays 0; all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the unified-memory port arbiter.
//   owner_e   : tag of the read source whose data returns next cycle
//   byte2word : byte address -> word address (drops the two byte-lane bits)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_DM_RD = 2'd2,
        OWN_DBG   = 2'd3
    } owner_e;

    function automatic logic [29:0] byte2word(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: all requester, debug and memory-macro signals of the
// arbiter.
//   slave  : arbiter side (requests and mem_rdata in; grants, returns, mem_* out)
//   master : environment side (pipeline, display, memory macro)
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 10
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [31:0]   dm_rdata;
    logic [7:0]    addr_sel;
    logic [31:0]   dbg_data;
    logic          dbg_fresh;
    logic          stall_if;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, addr_sel, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               dbg_data, dbg_fresh, stall_if, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, addr_sel, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               dbg_data, dbg_fresh, stall_if, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_dbg_refresh_timer.sv
// dbg_refresh_timer: decides when the display readout needs a fresh memory read.
//   clk, rst_n   : clock, async active-low reset
//   addr_sel     : debug word address; any change requests a read
//   dbg_gnt      : debug read granted this cycle
//   dbg_pending  : a debug read is outstanding
//   dbg_force    : outstanding read has waited DBG_MAX_WAIT cycles
module dbg_refresh_timer #(
    parameter int unsigned DBG_PERIOD   = 64,
    parameter int unsigned DBG_MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr_sel,
    input  logic       dbg_gnt,
    output logic       dbg_pending,
    output logic       dbg_force
);

    localparam int unsigned PW   = (DBG_PERIOD > 1) ? $clog2(DBG_PERIOD) : 1;
    localparam int unsigned AGEW = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [PW-1:0]   PER_LAST = PW'(DBG_PERIOD - 1);
    localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(DBG_MAX_WAIT);

    logic [PW-1:0]   r_period;
    logic [7:0]      r_sel;
    logic            r_pending;
    logic [AGEW-1:0] r_age;
    logic            w_period_hit;
    logic            w_sel_chg;

    assign w_period_hit = (r_period == PER_LAST);
    assign w_sel_chg    = (addr_sel != r_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period  <= '0;
            r_sel     <= '0;
            r_pending <= 1'b1;
            r_age     <= '0;
        end else begin
            r_period <= w_period_hit ? '0 : r_period + PW'(1);
            r_sel    <= addr_sel;
            // a new refresh reason arriving in the grant cycle wins over the clear
            r_pending <= w_period_hit | w_sel_chg | (r_pending & ~dbg_gnt);
            if (dbg_gnt)
                r_age <= '0;
            else if (r_pending && (r_age != AGE_MAX))
                r_age <= r_age + AGEW'(1);
        end
    end

    assign dbg_pending = r_pending;
    assign dbg_force   = r_pending && (r_age == AGE_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between data
// access, instruction fetch and the display debug readout.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_port_arbiter_if.slave (requests, grants, read returns,
//                debug readout, fetch stall, memory-macro port)
// Grants are combinational in the request cycle; read data returns the next
// cycle, steered by a registered owner tag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 10,
    parameter int unsigned DBG_PERIOD   = 64,
    parameter int unsigned DBG_MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    logic        w_pending;
    logic        w_force;
    logic        w_dbg_gnt;
    logic        w_dm_gnt;
    logic        w_if_gnt;
    logic [29:0] w_if_word;
    logic [29:0] w_dm_word;
    logic        w_unused_addr_bits;
    owner_e      w_owner_nxt;
    owner_e      r_owner;
    logic [31:0] r_dbg_data;

    dbg_refresh_timer #(
        .DBG_PERIOD   (DBG_PERIOD),
        .DBG_MAX_WAIT (DBG_MAX_WAIT)
    ) u_dbg_refresh_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_sel    (bus.addr_sel),
        .dbg_gnt     (w_dbg_gnt),
        .dbg_pending (w_pending),
        .dbg_force   (w_force)
    );

    assign w_if_word          = byte2word(bus.if_addr);
    assign w_dm_word          = byte2word(bus.dm_addr);
    assign w_unused_addr_bits = ^{w_if_word[29:AW], w_dm_word[29:AW]};

    // Priority: forced debug > data > fetch > debug. Grants are held off
    // while in reset so every output reads 0.
    assign w_dbg_gnt = rst_n & (w_force | (w_pending & ~bus.dm_req & ~bus.if_req));
    assign w_dm_gnt  = rst_n & ~w_force & bus.dm_req;
    assign w_if_gnt  = rst_n & ~w_force & ~bus.dm_req & bus.if_req;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        w_owner_nxt   = OWN_NONE;
        if (w_dbg_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = AW'(bus.addr_sel);
            w_owner_nxt  = OWN_DBG;
        end else if (w_dm_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dm_we;
            bus.mem_addr  = w_dm_word[AW-1:0];
            bus.mem_wdata = bus.dm_wdata;
            w_owner_nxt   = bus.dm_we ? OWN_NONE : OWN_DM_RD;
        end else if (w_if_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = w_if_word[AW-1:0];
            w_owner_nxt  = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_NONE;
            r_dbg_data <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            if (r_owner == OWN_DBG)
                r_dbg_data <= bus.mem_rdata;
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.stall_if  = bus.if_req & ~w_if_gnt & rst_n;
    assign bus.if_rvalid = (r_owner == OWN_IF);
    assign bus.dm_rvalid = (r_owner == OWN_DM_RD);
    assign bus.dbg_fresh = (r_owner == OWN_DBG);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;
    // new debug value is visible in its fresh cycle, then held in r_dbg_data
    assign bus.dbg_data  = bus.dbg_fresh ? bus.mem_rdata : r_dbg_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed stimulus for mem_port_arbiter,
// checked by a scoreboard fed from a behavioural reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW           = 10;
    localparam int unsigned DBG_PERIOD   = 64;
    localparam int unsigned DBG_MAX_WAIT = 8;
    localparam int unsigned DEPTH        = 1 << AW;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(
        .AW           (AW),
        .DBG_PERIOD   (DBG_PERIOD),
        .DBG_MAX_WAIT (DBG_MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory macro: registered read, one-cycle latency
    logic [31:0] dmem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                dmem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= dmem[bus.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic          if_gnt;
        logic          dm_gnt;
        logic          stall;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   dbg;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } ret_t;

    gexp_t gnt_q [$];
    ret_t  if_q  [$];
    ret_t  dm_q  [$];
    ret_t  dbg_q [$];

    logic [31:0] ref_mem [DEPTH];
    bit          m_pending;
    int          m_wait;
    int          m_phase;
    int          m_last_sel;
    logic [31:0] m_dbg_val;
    bit          pred_if_gnt;
    bit          pred_dm_gnt;

    function automatic int unsigned widx(logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic void model_reset();
        m_pending  = 1'b1;
        m_wait     = 0;
        m_phase    = 0;
        m_last_sel = 0;
        m_dbg_val  = '0;
    endfunction

    // One clock of arbitration decided from the inputs currently driven.
    function automatic void model_step();
        gexp_t e;
        ret_t  r;
        bit    force_dbg, g_dbg, g_dm, g_if;
        int    sel;
        sel   = int'(bus.addr_sel);
        g_dbg = 0; g_dm = 0; g_if = 0;
        force_dbg = m_pending && (m_wait == DBG_MAX_WAIT);
        if (force_dbg)        g_dbg = 1;
        else if (bus.dm_req)  g_dm  = 1;
        else if (bus.if_req)  g_if  = 1;
        else if (m_pending)   g_dbg = 1;

        e.if_gnt = g_if;
        e.dm_gnt = g_dm;
        e.stall  = bus.if_req && !g_if;
        e.en     = g_dbg || g_dm || g_if;
        e.we     = g_dm && bus.dm_we;
        e.addr   = g_dbg ? AW'(sel) : g_dm ? AW'(widx(bus.dm_addr)) :
                   g_if  ? AW'(widx(bus.if_addr)) : '0;
        e.wdata  = bus.dm_wdata;
        e.dbg    = m_dbg_val;
        gnt_q.push_back(e);

        r.cyc = cyc;
        if (g_if) begin
            r.data = ref_mem[widx(bus.if_addr)];
            if_q.push_back(r);
        end
        if (g_dm && !bus.dm_we) begin
            r.data = ref_mem[widx(bus.dm_addr)];
            dm_q.push_back(r);
        end
        if (g_dm && bus.dm_we)
            ref_mem[widx(bus.dm_addr)] = bus.dm_wdata;
        if (g_dbg) begin
            r.data = ref_mem[sel];
            dbg_q.push_back(r);
            m_dbg_val = ref_mem[sel];
        end

        if (g_dbg)          m_wait = 0;
        else if (m_pending) m_wait = (m_wait < DBG_MAX_WAIT) ? m_wait + 1 : DBG_MAX_WAIT;
        m_pending  = (m_phase == DBG_PERIOD - 1) || (sel != m_last_sel) || (m_pending && !g_dbg);
        m_phase    = (m_phase + 1) % DBG_PERIOD;
        m_last_sel = sel;
        pred_if_gnt = g_if;
        pred_dm_gnt = g_dm;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        gexp_t e;
        ret_t  r;
        if (gnt_q.size() > 0) begin
            e = gnt_q.pop_front();
            chk("if_gnt",   32'(bus.if_gnt),   32'(e.if_gnt));
            chk("dm_gnt",   32'(bus.dm_gnt),   32'(e.dm_gnt));
            chk("stall_if", 32'(bus.stall_if), 32'(e.stall));
            chk("mem_en",   32'(bus.mem_en),   32'(e.en));
            chk("mem_we",   32'(bus.mem_we),   32'(e.we));
            if (e.en) chk("mem_addr",  32'(bus.mem_addr), 32'(e.addr));
            if (e.we) chk("mem_wdata", bus.mem_wdata,     e.wdata);
            chk("dbg_data_held", bus.dbg_data, e.dbg);
        end
        if (bus.if_rvalid) begin
            if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                r = if_q.pop_front();
                chk("if_rdata", bus.if_rdata, r.data);
                chk("if_latency", 32'(cyc), 32'(r.cyc + 1));
            end
        end
        if (bus.dm_rvalid) begin
            if (dm_q.size() == 0) chk("dm_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                r = dm_q.pop_front();
                chk("dm_rdata", bus.dm_rdata, r.data);
                chk("dm_latency", 32'(cyc), 32'(r.cyc + 1));
            end
        end
        if (bus.dbg_fresh) begin
            if (dbg_q.size() == 0) chk("dbg_fresh_unexpected", 32'd1, 32'd0);
            else begin
                r = dbg_q.pop_front();
                chk("dbg_data_fresh", bus.dbg_data, r.data);
                chk("dbg_latency", 32'(cyc), 32'(r.cyc + 1));
            end
        end
    end

    // ---------------- driver ----------------
    bit          d_if_pend, d_dm_pend, d_dm_we;
    logic [31:0] d_if_addr, d_dm_addr, d_dm_wdata;
    logic [7:0]  d_sel;

    // called at posedge+1: drive this cycle's inputs and predict the outcome
    task automatic step_drive();
        bus.if_req   = d_if_pend;
        bus.if_addr  = d_if_addr;
        bus.dm_req   = d_dm_pend;
        bus.dm_we    = d_dm_we;
        bus.dm_addr  = d_dm_addr;
        bus.dm_wdata = d_dm_wdata;
        bus.addr_sel = d_sel;
        model_step();
        if (pred_if_gnt) d_if_pend = 0;
        if (pred_dm_gnt) d_dm_pend = 0;
    endtask

    task automatic step_end();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        step_drive();
        step_end();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(63) << 2) | $urandom_range(3);
        if ($urandom_range(3) == 0) a = a | ($urandom() & 32'hFFFF_F000);
        return a;
    endfunction

    task automatic run_random(int n, int p_if, int p_dm);
        for (int i = 0; i < n; i++) begin
            if (!d_if_pend && $urandom_range(99) < p_if) begin
                d_if_pend = 1;
                d_if_addr = rand_addr();
            end
            if (!d_dm_pend && $urandom_range(99) < p_dm) begin
                d_dm_pend  = 1;
                d_dm_we    = ($urandom_range(9) < 4);
                d_dm_addr  = rand_addr();
                d_dm_wdata = $urandom();
            end
            if ($urandom_range(99) < 3) d_sel = 8'($urandom_range(255));
            step();
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({tag, "_dm_gnt"},    32'(bus.dm_gnt),    32'd0);
        chk({tag, "_dm_rvalid"}, 32'(bus.dm_rvalid), 32'd0);
        chk({tag, "_dbg_fresh"}, 32'(bus.dbg_fresh), 32'd0);
        chk({tag, "_dbg_data"},  bus.dbg_data,       32'd0);
        chk({tag, "_stall_if"},  32'(bus.stall_if),  32'd0);
        chk({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_block;
        int waited;
        for (int i = 0; i < int'(DEPTH); i++) begin
            dmem[i]    = $urandom();
            ref_mem[i] = dmem[i];
        end
        bus.mem_rdata = '0;
        d_if_pend = 0; d_dm_pend = 0; d_dm_we = 0;
        d_if_addr = '0; d_dm_addr = '0; d_dm_wdata = '0; d_sel = '0;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.addr_sel = '0;
        rst_n = 1'b0;
        model_reset();

        @(posedge clk); #1;
        @(negedge clk); #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // first idle cycle after reset: debug read of word 0
        step_drive(); #2;
        chk("boot_dbg_en",   32'(bus.mem_en),   32'd1);
        chk("boot_dbg_addr", 32'(bus.mem_addr), 32'd0);
        step_end();
        step_drive(); #2;
        chk("boot_dbg_fresh", 32'(bus.dbg_fresh), 32'd1);
        chk("boot_dbg_data",  bus.dbg_data,       ref_mem[0]);
        step_end();

        // lone fetch
        d_if_pend = 1; d_if_addr = 32'h10;
        step_drive(); #2;
        chk("if_only_gnt",  32'(bus.if_gnt),   32'd1);
        chk("if_only_addr", 32'(bus.mem_addr), 32'd4);
        step_end();
        step_drive(); #2;
        chk("if_only_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("if_only_rdata",  bus.if_rdata,       ref_mem[4]);
        step_end();

        // data beats fetch, fetch follows
        d_if_pend = 1; d_if_addr = 32'h20;
        d_dm_pend = 1; d_dm_we = 0; d_dm_addr = 32'h20;
        step_drive(); #2;
        chk("contend_dm_gnt", 32'(bus.dm_gnt),   32'd1);
        chk("contend_if_gnt", 32'(bus.if_gnt),   32'd0);
        chk("contend_stall",  32'(bus.stall_if), 32'd1);
        step_end();
        step_drive(); #2;
        chk("contend_if_next", 32'(bus.if_gnt), 32'd1);
        step_end();
        step();

        // write then read back
        d_dm_pend = 1; d_dm_we = 1; d_dm_addr = 32'h8; d_dm_wdata = 32'hDEADBEEF;
        step_drive(); #2;
        chk("wr_mem_we",   32'(bus.mem_we),   32'd1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'd2);
        step_end();
        step_drive(); #2;
        chk("wr_no_rvalid", 32'(bus.dm_rvalid), 32'd0);
        step_end();
        d_dm_pend = 1; d_dm_we = 0; d_dm_addr = 32'h8;
        step();
        step_drive(); #2;
        chk("rd_back_rvalid", 32'(bus.dm_rvalid), 32'd1);
        chk("rd_back_data",   bus.dm_rdata,       32'hDEADBEEF);
        step_end();

        // continuous data traffic while addr_sel changes: one forced debug
        d_sel   = 8'd5;
        n_block = 0;
        for (int i = 0; i < 14; i++) begin
            if (!d_dm_pend) begin
                d_dm_pend = 1; d_dm_we = 0; d_dm_addr = rand_addr();
            end
            step_drive(); #2;
            if (bus.dm_req && !bus.dm_gnt) n_block++;
            step_end();
        end
        d_dm_pend = 0;
        chk("force_blocks_once", 32'(n_block), 32'd1);
        step(); step();
        chk("force_dbg_data", bus.dbg_data, ref_mem[5]);

        run_random(400, 90, 90);
        run_random(400, 20, 20);
        run_random(400, 60, 95);

        // reset in the cycle after a fetch grant drops the return
        d_dm_pend = 0;
        d_if_pend = 1; d_if_addr = 32'h40;
        waited = 0;
        while (d_if_pend && waited < 20) begin
            step();
            waited++;
        end
        chk("pre_reset_if_granted", 32'(d_if_pend), 32'd0);
        rst_n = 1'b0;
        if_q.delete(); dm_q.delete(); dbg_q.delete(); gnt_q.delete();
        bus.if_req = 1; bus.dm_req = 1;
        #2;
        check_all_zero("midrst");
        @(posedge clk); #1;
        chk("midrst_if_rvalid2", 32'(bus.if_rvalid), 32'd0);
        bus.if_req = 0; bus.dm_req = 0;
        d_if_pend = 0; d_dm_pend = 0;
        model_reset();
        rst_n = 1'b1;

        run_random(300, 50, 50);

        d_if_pend = 0; d_dm_pend = 0;
        @(negedge clk); @(negedge clk); #1;
        chk("if_q_left",  32'(if_q.size()),  32'd0);
        chk("dm_q_left",  32'(dm_q.size()),  32'd0);
        chk("dbg_q_left", 32'(dbg_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
